// File: rtl/alu_pkg.sv
// Shared ALU package: data word, width constant and condition-flag bundle
// used by the and/add/sub/xor ALU blocks.
package alu_pkg;

   localparam int unsigned XLEN = 64;

   // Signed machine word
   typedef logic signed [XLEN-1:0] data_t;

   // Condition flags produced by the logic/arith units
   typedef struct packed {
      logic zf;
      logic sf;
   } flags_t;

endpackage : alu_pkg

// File: rtl/and64_and1.sv
// Single-bit AND cell, gate-primitive style shared with sibling ALU blocks.
module and1 (
   input  logic a,
   input  logic b,
   output logic y
);

   and u_and (y, a, b);

endmodule : and1

// File: rtl/and64.sv
// and64: WIDTH-bit bitwise AND unit with ZF/SF condition flags.
// Default build registers ans/flags/out_valid with one cycle of latency.
// Defining AND64_COMB_EN removes the output register and makes the unit
// purely combinational (clk/rst kept as ports but unused).
module and64
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = XLEN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] ans,
   output logic                    out_valid,
   output logic                    zf,
   output logic                    sf
);

   logic signed [WIDTH-1:0] and_w;
   flags_t                  flags_c;

   // Bit-slice array of AND cells
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      and1 u_and1 (
         .a (a[i]),
         .b (b[i]),
         .y (and_w[i])
      );
   end

   // Flags derived from the combinational result so they stay coherent with ans
   always_comb begin
      flags_c    = '0;
      flags_c.zf = ~(|and_w);
      flags_c.sf = and_w[WIDTH-1];
   end

`ifdef AND64_COMB_EN

   logic unused_clk_rst;

   assign unused_clk_rst = clk ^ rst;
   assign ans            = and_w;
   assign zf             = flags_c.zf;
   assign sf             = flags_c.sf;
   assign out_valid      = in_valid;

`else

   logic signed [WIDTH-1:0] ans_q, ans_d;
   flags_t                  flags_q, flags_d;
   logic                    out_valid_q, out_valid_d;

   // Next-state: capture on valid, otherwise hold data/flags and drop valid
   always_comb begin
      ans_d       = ans_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         ans_d       = and_w;
         flags_d     = flags_c;
         out_valid_d = 1'b1;
      end
   end

   // Output register with synchronous reset taking priority over in_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         ans_q       <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         ans_q       <= ans_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign ans       = ans_q;
   assign zf        = flags_q.zf;
   assign sf        = flags_q.sf;
   assign out_valid = out_valid_q;

`endif

endmodule : and64

// File: tb/tb_and64.sv
// Self-checking bench for and64 (registered build, or combinational build
// when AND64_COMB_EN is defined).
module tb_and64;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [63:0] a;
   logic [63:0] b;
   logic [63:0] ans;
   logic        out_valid;
   logic        zf;
   logic        sf;

   int checks = 0;
   int passed = 0;

   // Reference state: what the outputs must show after the latest edge
   logic [63:0] m_ans;
   logic        m_zf, m_sf, m_ov;

   logic [66:0] obs, exp;

   and64 #(.WIDTH(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .ans       (ans),
      .out_valid (out_valid),
      .zf        (zf),
      .sf        (sf)
   );

   always #5 clk = ~clk;

   // Bit-by-bit conjunction, as the function is defined
   function automatic logic [63:0] ref_and(input logic [63:0] x, input logic [63:0] y);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = (x[i] == 1'b1) && (y[i] == 1'b1);
      return r;
   endfunction

`ifdef AND64_COMB_EN

   // Combinational: settle inputs then compare against same-cycle reference
   task automatic test_comb();
      logic [63:0] ca [0:5];
      logic [63:0] cb [0:5];
      logic [63:0] r;
      ca[0] = 64'hFFFF_FFFF_FFFF_FFF5; cb[0] = 64'hC;
      ca[1] = -64'sd2;                 cb[1] = 64'd13;
      ca[2] = -64'sd2;                 cb[2] = -64'sd13;
      ca[3] = 64'hFFFF_FFFF_FFFF_FFFF; cb[3] = 64'h8000_0000_0000_0000;
      ca[4] = 64'h5555_5555_5555_5555; cb[4] = 64'hAAAA_AAAA_AAAA_AAAA;
      ca[5] = 64'h0;                   cb[5] = 64'h0;
      for (int k = 0; k < 30; k++) begin
         in_valid = 1'(k % 3 != 0);
         rst      = 1'(k % 4 == 1);
         if (k < 6) begin
            a = ca[k]; b = cb[k];
         end else begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
         end
         #3;
         r   = ref_and(a, b);
         obs = {out_valid, zf, sf, ans};
         exp = {in_valid, r == 64'h0, r[63], r};
         checks++;
         if (obs !== exp)
            $display("FAIL comb_%0d: got ov/zf/sf/ans=%h want %h", k, obs, exp);
         else passed++;
      end
   endtask

`else

   // One clock: drive inputs, advance reference model, step past the edge
   task automatic cycle(input logic r_i, input logic v_i,
                        input logic [63:0] a_i, input logic [63:0] b_i);
      logic [63:0] r;
      rst = r_i; in_valid = v_i; a = a_i; b = b_i;
      @(posedge clk);
      if (r_i) begin
         m_ans = '0; m_zf = 1'b0; m_sf = 1'b0; m_ov = 1'b0;
      end else if (v_i) begin
         r = ref_and(a_i, b_i);
         m_ans = r; m_zf = (r == 64'h0); m_sf = r[63]; m_ov = 1'b1;
      end else begin
         m_ov = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         cycle(1'b1, 1'b1, 64'hF, 64'hF);
         obs = {out_valid, zf, sf, ans};
         exp = {1'b0, 1'b0, 1'b0, 64'h0};
         checks++;
         if (obs !== exp) $display("FAIL reset_%0d: got %h want %h", k, obs, exp);
         else passed++;
      end
      cycle(1'b0, 1'b1, 64'h0, 64'h0);
      obs = {out_valid, zf, sf, ans};
      exp = {1'b1, 1'b1, 1'b0, 64'h0};
      checks++;
      if (obs !== exp) $display("FAIL reset_first_op: got %h want %h", obs, exp);
      else passed++;
   endtask

   task automatic test_bitwise();
      logic [63:0] ta [0:2];
      logic [63:0] tb [0:2];
      logic [63:0] te [0:2];
      ta[0] = 64'b1011; tb[0] = 64'b0100; te[0] = 64'h0;
      ta[1] = 64'b1011; tb[1] = 64'b1100; te[1] = 64'b1000;
      ta[2] = 64'b1001; tb[2] = 64'b1001; te[2] = 64'b1001;
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, ta[k], tb[k]);
         obs = {out_valid, zf, sf, ans};
         exp = {1'b1, te[k] == 64'h0, 1'b0, te[k]};
         checks++;
         if (obs !== exp) $display("FAIL bitwise_%0d: got %h want %h", k, obs, exp);
         else passed++;
      end
   endtask

   task automatic test_negative();
      logic [63:0] na [0:2];
      logic [63:0] nb [0:2];
      logic [63:0] ne [0:2];
      na[0] = 64'hFFFF_FFFF_FFFF_FFF5; nb[0] = 64'hC;          ne[0] = 64'h4;
      na[1] = -64'sd2;                 nb[1] = 64'd13;         ne[1] = 64'd12;
      na[2] = -64'sd2;                 nb[2] = -64'sd13;       ne[2] = 64'hFFFF_FFFF_FFFF_FFF2;
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, na[k], nb[k]);
         obs = {out_valid, zf, sf, ans};
         exp = {1'b1, 1'b0, ne[k][63], ne[k]};
         checks++;
         if (obs !== exp) $display("FAIL negative_%0d: got %h want %h", k, obs, exp);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] sa [0:4];
      logic [63:0] sb [0:4];
      logic [66:0] held;
      sa[0] = 64'b1011;  sb[0] = 64'b0100;
      sa[1] = 64'b1011;  sb[1] = 64'b1100;
      sa[2] = 64'b1001;  sb[2] = 64'b1001;
      sa[3] = -64'sd2;   sb[3] = 64'd13;
      sa[4] = -64'sd2;   sb[4] = -64'sd13;
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b1, sa[k], sb[k]);
         obs = {out_valid, zf, sf, ans};
         exp = {m_ov, m_zf, m_sf, m_ans};
         checks++;
         if (obs !== exp) $display("FAIL stream_%0d: got %h want %h", k, obs, exp);
         else passed++;
      end
      held = {1'b0, m_zf, m_sf, m_ans};
      for (int k = 0; k < 4; k++) begin
         if (k == 3) cycle(1'b0, 1'b0, 'x, 'x);
         else cycle(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
         obs = {out_valid, zf, sf, ans};
         checks++;
         if (obs !== held) $display("FAIL hold_%0d: got %h want %h", k, obs, held);
         else passed++;
      end
   endtask

   task automatic test_extremes();
      cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
      obs = {out_valid, zf, sf, ans};
      exp = {1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000};
      checks++;
      if (obs !== exp) $display("FAIL extreme_msb: got %h want %h", obs, exp);
      else passed++;
      cycle(1'b0, 1'b1, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA);
      obs = {out_valid, zf, sf, ans};
      exp = {1'b1, 1'b1, 1'b0, 64'h0};
      checks++;
      if (obs !== exp) $display("FAIL extreme_alt: got %h want %h", obs, exp);
      else passed++;
   endtask

   task automatic test_reset_midstream();
      cycle(1'b0, 1'b1, 64'hFFFF_0000_FFFF_0000, 64'hF0F0_F0F0_F0F0_F0F0);
      cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      obs = {out_valid, zf, sf, ans};
      exp = {1'b0, 1'b0, 1'b0, 64'h0};
      checks++;
      if (obs !== exp) $display("FAIL midreset: got %h want %h", obs, exp);
      else passed++;
      cycle(1'b0, 1'b1, 64'h8000_0000_0000_00FF, 64'hC000_0000_0000_000F);
      obs = {out_valid, zf, sf, ans};
      exp = {1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_000F};
      checks++;
      if (obs !== exp) $display("FAIL midreset_resume: got %h want %h", obs, exp);
      else passed++;
   endtask

   task automatic test_random();
      for (int k = 0; k < 60; k++) begin
         logic [63:0] ra, rb;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (k % 7 == 3) rb = ~ra;
         cycle(1'((k % 13) == 12), 1'($urandom_range(0, 3) != 0), ra, rb);
         obs = {out_valid, zf, sf, ans};
         exp = {m_ov, m_zf, m_sf, m_ans};
         checks++;
         if (obs !== exp) $display("FAIL random_%0d: got %h want %h", k, obs, exp);
         else passed++;
      end
   endtask

`endif

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
      m_ans = '0; m_zf = 1'b0; m_sf = 1'b0; m_ov = 1'b0;
`ifdef AND64_COMB_EN
      test_comb();
`else
      test_reset();
      test_bitwise();
      test_negative();
      test_back_to_back();
      test_extremes();
      test_reset_midstream();
      test_random();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_and64
